// File: rtl/la_bridge_pkg.sv
// Shared types and LA bus field positions for the host command bridge.
// The captured command struct mirrors the la_cmd_i[63:0] layout exactly.
package la_bridge_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_CTRL  = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ISSUE  = 2'b01,
    ST_WAIT_R = 2'b10,
    ST_DONE   = 2'b11
  } state_e;

  typedef struct packed {
    opcode_e     op;
    logic [29:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  localparam int CMD_WIDTH      = 65;
  localparam int CMD_TOGGLE_BIT = 64;
  localparam int CMD_OP_MSB     = 63;
  localparam int CMD_OP_LSB     = 62;
  localparam int CMD_ADDR_MSB   = 61;
  localparam int CMD_ADDR_LSB   = 32;
  localparam int CMD_WDATA_MSB  = 31;
  localparam int CMD_WDATA_LSB  = 0;

  localparam int RSP_WIDTH      = 111;
  localparam int RSP_RDATA_MSB  = 31;
  localparam int RSP_RDATA_LSB  = 0;
  localparam int RSP_ADDR_MSB   = 61;
  localparam int RSP_ADDR_LSB   = 32;
  localparam int RSP_ACK_BIT    = 62;
  localparam int RSP_BUSY_BIT   = 63;
  localparam int RSP_ERR_TO_BIT = 64;
  localparam int RSP_ERR_OV_BIT = 65;
  localparam int RSP_HALT_BIT   = 66;
  localparam int RSP_CNT_MSB    = 74;
  localparam int RSP_CNT_LSB    = 67;

  function automatic logic is_mem_op(input opcode_e op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

endpackage

// File: rtl/la_toggle_sync.sv
// Synchronises the host command-toggle bit and turns each level change into a
// single-cycle event pulse, registered so downstream logic sees a clean flop output.
module la_toggle_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic toggle_i,
  output logic level_o,
  output logic event_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;
  logic                   event_q, event_d;

  always_comb begin
    // NOTE: every always_comb output gets a value before any branch, so no latch is inferred.
    sync_d    = '0;
    sync_d[0] = toggle_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    level_d = sync_q[SYNC_STAGES-1];
    event_d = sync_q[SYNC_STAGES-1] ^ level_q;
  end

  // NOTE: state updates use <= so every flop samples pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      event_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      event_q <= event_d;
    end
  end

  assign level_o = level_q;
  assign event_o = event_q;

endmodule

// File: rtl/la_cmd_bridge.sv
// Decodes toggle-handshake LA commands into word memory accesses and core halt
// control, reporting status, errors and read data back on the LA response bus.
module la_cmd_bridge
  import la_bridge_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic [64:0]  la_cmd_i,
  output logic [110:0] la_rsp_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [29:0]  mem_addr_o,
  output logic [31:0]  mem_wdata_o,
  input  logic         mem_gnt_i,
  input  logic         mem_rvalid_i,
  input  logic [31:0]  mem_rdata_i,
  output logic         core_halt_o
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic cmd_event;
  logic toggle_level_unused;

  la_toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_toggle_sync (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_ni),
    .toggle_i (la_cmd_i[CMD_TOGGLE_BIT]),
    .level_o  (toggle_level_unused),
    .event_o  (cmd_event)
  );

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [29:0]      addr_q, addr_d;
  logic             ack_q, ack_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             err_to_q, err_to_d;
  logic             err_ov_q, err_ov_d;
  logic             halt_q, halt_d;

  opcode_e          new_op;
  logic             tmo_hit;

  assign new_op  = opcode_e'(la_cmd_i[CMD_OP_MSB:CMD_OP_LSB]);
  assign tmo_hit = (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    tmo_cnt_d = tmo_cnt_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    ack_d     = ack_q;
    cnt_d     = cnt_q;
    err_to_d  = err_to_q;
    err_ov_d  = err_ov_q;
    halt_d    = halt_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_event) begin
          cmd_d = cmd_t'(la_cmd_i[CMD_OP_MSB:CMD_WDATA_LSB]);
          if (is_mem_op(new_op)) begin
            state_d   = ST_ISSUE;
            tmo_cnt_d = '0;
          end else begin
            state_d = ST_DONE;
          end
        end
      end

      ST_ISSUE: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (mem_gnt_i) begin
          if (cmd_q.op == OP_WRITE) begin
            state_d = ST_DONE;
          end else if (mem_rvalid_i) begin
            // Grant and data together: the read is already complete.
            rdata_d = mem_rdata_i;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_R;
          end
        end else if (tmo_hit) begin
          err_to_d = 1'b1;
          state_d  = ST_DONE;
        end
      end

      ST_WAIT_R: begin
        // Counter keeps running from ISSUE entry, bounding the whole access.
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (mem_rvalid_i) begin
          rdata_d = mem_rdata_i;
          state_d = ST_DONE;
        end else if (tmo_hit) begin
          err_to_d = 1'b1;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        ack_d   = ~ack_q;
        cnt_d   = cnt_q + 8'd1;
        addr_d  = cmd_q.addr;
        state_d = ST_IDLE;
        case (cmd_q.op)
          OP_NOP: begin
            err_to_d = 1'b0;
            err_ov_d = 1'b0;
          end
          OP_CTRL: halt_d = cmd_q.wdata[0];
          default: ;
        endcase
      end

      default: state_d = ST_IDLE;
    endcase

    // Placed last so a dropped command wins over a same-cycle NOP clear.
    if (cmd_event && (state_q != ST_IDLE)) begin
      err_ov_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      tmo_cnt_q <= '0;
      rdata_q   <= '0;
      addr_q    <= '0;
      ack_q     <= 1'b0;
      cnt_q     <= '0;
      err_to_q  <= 1'b0;
      err_ov_q  <= 1'b0;
      halt_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      tmo_cnt_q <= tmo_cnt_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      ack_q     <= ack_d;
      cnt_q     <= cnt_d;
      err_to_q  <= err_to_d;
      err_ov_q  <= err_ov_d;
      halt_q    <= halt_d;
    end
  end

  // Decoded from state so reset drops the request without waiting for an edge.
  assign mem_req_o   = (state_q == ST_ISSUE);
  assign mem_we_o    = (cmd_q.op == OP_WRITE);
  assign mem_addr_o  = cmd_q.addr;
  assign mem_wdata_o = cmd_q.wdata;
  assign core_halt_o = halt_q;

  always_comb begin
    la_rsp_o                              = '0;
    la_rsp_o[RSP_RDATA_MSB:RSP_RDATA_LSB] = rdata_q;
    la_rsp_o[RSP_ADDR_MSB:RSP_ADDR_LSB]   = addr_q;
    la_rsp_o[RSP_ACK_BIT]                 = ack_q;
    la_rsp_o[RSP_BUSY_BIT]                = (state_q != ST_IDLE);
    la_rsp_o[RSP_ERR_TO_BIT]              = err_to_q;
    la_rsp_o[RSP_ERR_OV_BIT]              = err_ov_q;
    la_rsp_o[RSP_HALT_BIT]                = halt_q;
    la_rsp_o[RSP_CNT_MSB:RSP_CNT_LSB]     = cnt_q;
  end

endmodule

// File: tb/tb_la_cmd_bridge.sv
// Randomised scoreboard bench for la_cmd_bridge: a host driver, a reactive memory
// responder and an ack monitor, with expectations from a command-level model.
module tb_la_cmd_bridge;
  import la_bridge_pkg::*;

  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [64:0]  la_cmd;
  logic [110:0] la_rsp;
  logic         mem_req, mem_we;
  logic [29:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_gnt, mem_rvalid;
  logic [31:0]  mem_rdata;
  logic         core_halt;

  la_cmd_bridge #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .la_cmd_i     (la_cmd),
    .la_rsp_o     (la_rsp),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .core_halt_o  (core_halt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Command-level model of the host-visible state.
  logic        m_ack, m_halt, m_err_to, m_err_ov;
  logic [7:0]  m_cnt;
  logic [29:0] m_addr;
  logic [31:0] m_rdata;

  function automatic logic [110:0] model_rsp();
    return {36'd0, m_cnt, m_halt, m_err_ov, m_err_to, 1'b0, m_ack, m_addr, m_rdata};
  endfunction

  task automatic model_reset();
    m_ack = 0; m_halt = 1; m_err_to = 0; m_err_ov = 0;
    m_cnt = 0; m_addr = 0; m_rdata = 0;
  endtask

  typedef struct {
    logic        we;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          g;
    int          r;
    bit          simul;
    bit          spur;
    bit          never;
  } mem_op_t;

  mem_op_t      mem_q[$];
  logic [110:0] exp_q[$];
  bit           stray_ok = 0;

  task automatic send_cmd(input logic [1:0] op, input logic [29:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd, input int g, input int r, input bit simul,
                          input bit spur, input bit never, input bit overrun);
    mem_op_t m;
    logic    start_ack;
    int      n;
    if (op == OP_WRITE || op == OP_READ) begin
      m.we = (op == OP_WRITE); m.addr = addr; m.wdata = wdata; m.rdata = rd;
      m.g = g; m.r = r; m.simul = simul; m.spur = spur; m.never = never;
      mem_q.push_back(m);
    end
    m_ack  = ~m_ack;
    m_cnt  = m_cnt + 8'd1;
    m_addr = addr;
    case (op)
      OP_NOP:   begin m_err_to = 0; m_err_ov = 0; end
      OP_CTRL:  m_halt = wdata[0];
      OP_WRITE: if (never) m_err_to = 1;
      default:  if (never) m_err_to = 1; else m_rdata = rd;
    endcase
    if (overrun) m_err_ov = 1;
    exp_q.push_back(model_rsp());

    @(negedge clk);
    start_ack = la_rsp[62];
    la_cmd[63:0] = {op, addr, wdata};
    la_cmd[64]   = ~la_cmd[64];
    if (overrun) begin
      repeat (5) @(negedge clk);
      la_cmd[64] = ~la_cmd[64];
    end
    n = 0;
    while (la_rsp[62] === start_ack && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL ack_wait: no ack after %0d cycles, required a toggle", n);
    end
  endtask

  // Memory responder: serves each request according to its queued delays.
  initial begin : responder
    mem_op_t m;
    int      n;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req) begin
        if (mem_q.size() == 0) begin
          if (!stray_ok) begin
            checks++; failures++;
            $display("FAIL unexpected_req: got a request at addr %0h, required none", mem_addr);
          end
          n = 0;
          while (mem_req && rst_n && n < 100) begin @(negedge clk); n++; end
        end else begin
          m = mem_q.pop_front();
          check("mem_we", mem_we, m.we);
          check("mem_addr", mem_addr, m.addr);
          if (m.we) check("mem_wdata", mem_wdata, m.wdata);
          if (m.never) begin
            n = 0;
            while (mem_req && n < 100) begin @(negedge clk); n++; end
            check("req_cycles_to_timeout", n, TMO);
          end else begin
            if (m.spur && m.g > 0) begin
              mem_rvalid = 1; mem_rdata = ~m.rdata;
              @(negedge clk);
              mem_rvalid = 0;
              repeat (m.g - 1) @(negedge clk);
            end else begin
              repeat (m.g) @(negedge clk);
            end
            check("req_held_until_gnt", mem_req, 1'b1);
            mem_gnt = 1;
            if (!m.we && m.simul) begin mem_rvalid = 1; mem_rdata = m.rdata; end
            @(negedge clk);
            mem_gnt = 0; mem_rvalid = 0;
            if (!m.we && !m.simul) begin
              repeat (m.r) @(negedge clk);
              mem_rvalid = 1; mem_rdata = m.rdata;
              @(negedge clk);
              mem_rvalid = 0;
            end
          end
        end
      end
    end
  end

  // Ack monitor: every ack toggle pops one expected response.
  initial begin : monitor
    logic         prev_ack;
    logic [110:0] e;
    prev_ack = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ack = 0;
      end else if (la_rsp[62] !== prev_ack) begin
        prev_ack = la_rsp[62];
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_ack: got ack=%0b with nothing pending", prev_ack);
        end else begin
          e = exp_q.pop_front();
          check("rsp_at_ack", la_rsp, e);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [7:0] cnt_before;
    int         n;
    la_cmd = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("reset_rsp", la_rsp, model_rsp());
    check("reset_halt", core_halt, 1'b1);
    check("reset_req", mem_req, 1'b0);

    // WRITE with request latency measured from the host flip.
    fork
      send_cmd(OP_WRITE, 30'h10, 32'hDEADBEEF, 32'h0, 2, 0, 0, 0, 0, 0);
      begin
        @(la_cmd[64]);
        n = 0;
        while (!mem_req && n < 20) begin @(negedge clk); n++; end
        check("req_latency", n, 4);
      end
    join
    check("write_cnt", la_rsp[74:67], 8'd1);
    check("write_busy", la_rsp[63], 1'b0);

    send_cmd(OP_READ, 30'h10, 32'h0, 32'hCAFEF00D, 1, 2, 0, 1, 0, 0);
    check("read_rdata", la_rsp[31:0], 32'hCAFEF00D);
    check("read_addr", la_rsp[61:32], 30'h10);

    send_cmd(OP_READ, 30'h22, 32'h0, 32'h12345678, 0, 0, 0, 0, 1, 0);
    check("timeout_err", la_rsp[64], 1'b1);
    check("timeout_rdata_kept", la_rsp[31:0], 32'hCAFEF00D);
    send_cmd(OP_NOP, 30'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    check("nop_clears_timeout", la_rsp[64], 1'b0);

    send_cmd(OP_READ, 30'h33, 32'h0, 32'h0BADF00D, 5, 0, 0, 0, 0, 1);
    check("overrun_err", la_rsp[65], 1'b1);
    repeat (10) @(negedge clk);
    check("overrun_no_extra_ack", la_rsp[74:67], m_cnt);
    send_cmd(OP_NOP, 30'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);

    send_cmd(OP_CTRL, 30'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
    check("ctrl_halt_low", core_halt, 1'b0);
    check("ctrl_rsp_halt", la_rsp[66], 1'b0);
    send_cmd(OP_READ, 30'h44, 32'h0, 32'h5A5A0001, 0, 0, 1, 0, 0, 0);
    check("simul_rdata", la_rsp[31:0], 32'h5A5A0001);

    for (int i = 0; i < 80; i++) begin
      logic [1:0] op;
      int         g;
      op = 2'($urandom_range(0, 3));
      g  = $urandom_range(0, 3);
      send_cmd(op, 30'($urandom), $urandom, $urandom, g, $urandom_range(0, 2),
               ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0), 0);
    end
    check("halt_after_random", core_halt, m_halt);

    cnt_before = m_cnt;
    for (int i = 0; i < 256; i++) begin
      send_cmd(OP_NOP, 30'($urandom), $urandom, 32'h0, 0, 0, 0, 0, 0, 0);
    end
    check("cnt_wrap", la_rsp[74:67], cnt_before);

    // Reset while a request is outstanding.
    stray_ok = 1;
    @(negedge clk);
    la_cmd[63:0] = {OP_READ, 30'h55, 32'h0};
    la_cmd[64]   = ~la_cmd[64];
    n = 0;
    while (!mem_req && n < 20) begin @(negedge clk); n++; end
    check("mid_issue_req_seen", mem_req, 1'b1);
    rst_n = 0;
    la_cmd = '0;
    #1;
    check("reset_drops_req", mem_req, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("reset_again_rsp", la_rsp, model_rsp());
    check("scoreboard_drained", exp_q.size(), 0);
    check("mem_queue_drained", mem_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
